hyperram_csr_wb: RTL and testbench

Wishbone classic slave that owns the HyperRAM controller's configuration/status register bank and feeds the controller's configuration inputs. Bus writes land in byte-maskable staging registers; staged values are copied to the live configuration outputs only while the HyperRAM core reports idle, so a transfer never sees a configuration change mid-burst. It also returns status and ID read-back and flags illegal accesses with `wb_err_o`.

---
 rtl/hyperram_csr_wb.sv | 147 ++++++++++++++
 tb/tb_hyperram_csr_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_csr_wb.sv
// Wishbone classic CSR bank for the HyperRAM controller: staged config registers,
// idle-gated apply to live outputs, status/ID read-back and error termination.
module hyperram_csr_wb #(
  parameter logic [31:0] CTRL_DEFAULT   = 32'h0000_0016,
  parameter logic [31:0] TIMING_DEFAULT = 32'h0000_0404,
  parameter logic [31:0] ID_VALUE       = 32'h4852_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        core_idle,
  output logic [31:0] cfg_ctrl,
  output logic [31:0] cfg_timing,
  output logic        cfg_update
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE, RESP} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   ctrl_stage, timing_stage;
  logic [DW-1:0]   ctrl_next, timing_next;
  logic [DW-1:0]   dat_next, status_c;
  logic            ack_next, err_next;
  logic            pend_set, err_inc, err_clr, apply_c;
  logic            update_pending;
  logic [CW-1:0]   err_count;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old,
                                                input logic [DW-1:0] din,
                                                input logic [3:0]    sel);
    merge_bytes = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) merge_bytes[8*b +: 8] = din[8*b +: 8];
  endfunction

  assign apply_c  = update_pending & core_idle;
  assign status_c = {16'h0, err_count, 6'h0, core_idle, update_pending};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Decode one access in IDLE; the response is registered for the RESP cycle.
  always_comb begin
    state_next  = state;
    ack_next    = 1'b0;
    err_next    = 1'b0;
    dat_next    = '0;
    ctrl_next   = ctrl_stage;
    timing_next = timing_stage;
    pend_set    = 1'b0;
    err_inc     = 1'b0;
    err_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_next = RESP;
          case (wb_adr_i)
            4'd0: begin
              ack_next = 1'b1;
              if (wb_we_i) begin
                ctrl_next = merge_bytes(ctrl_stage, wb_dat_i, wb_sel_i);
                pend_set  = |wb_sel_i;
              end else begin
                dat_next = ctrl_stage;
              end
            end
            4'd1: begin
              ack_next = 1'b1;
              if (wb_we_i) begin
                timing_next = merge_bytes(timing_stage, wb_dat_i, wb_sel_i);
                pend_set    = |wb_sel_i;
              end else begin
                dat_next = timing_stage;
              end
            end
            4'd2: begin
              ack_next = 1'b1;
              if (wb_we_i) err_clr = wb_dat_i[31] & wb_sel_i[3];
              else         dat_next = status_c;
            end
            4'd3: begin
              if (wb_we_i) begin
                err_next = 1'b1;
                err_inc  = 1'b1;
              end else begin
                ack_next = 1'b1;
                dat_next = ID_VALUE;
              end
            end
            default: begin
              err_next = 1'b1;
              err_inc  = 1'b1;
            end
          endcase
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Apply copies pre-write staging; a same-edge write keeps the update pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o       <= 1'b0;
      wb_err_o       <= 1'b0;
      wb_dat_o       <= '0;
      ctrl_stage     <= CTRL_DEFAULT;
      timing_stage   <= TIMING_DEFAULT;
      cfg_ctrl       <= CTRL_DEFAULT;
      cfg_timing     <= TIMING_DEFAULT;
      cfg_update     <= 1'b0;
      update_pending <= 1'b0;
      err_count      <= '0;
    end else begin
      wb_ack_o       <= ack_next;
      wb_err_o       <= err_next;
      wb_dat_o       <= dat_next;
      ctrl_stage     <= ctrl_next;
      timing_stage   <= timing_next;
      cfg_update     <= apply_c;
      update_pending <= pend_set | (update_pending & ~core_idle);
      if (apply_c) begin
        cfg_ctrl   <= ctrl_stage;
        cfg_timing <= timing_stage;
      end
      if (err_clr)
        err_count <= '0;
      else if (err_inc && (err_count != {CW{1'b1}}))
        err_count <= err_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_hyperram_csr_wb.sv
// Self-checking bench for hyperram_csr_wb: directed literal checks plus random
// traffic compared every cycle against a transaction-level register model.
module tb_hyperram_csr_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        idle = 1'b0;
  logic [31:0] wb_dat_o, cfg_ctrl, cfg_timing;
  logic        wb_ack_o, wb_err_o, cfg_update;

  hyperram_csr_wb dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .core_idle(idle), .cfg_ctrl(cfg_ctrl), .cfg_timing(cfg_timing),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: register file, live copy, pending flag and error counter.
  logic [31:0] m_stage [2];
  logic [31:0] m_live  [2];
  bit          m_pend, m_busy;
  int          m_errs;
  logic [31:0] e_dat;
  bit          e_ack, e_err, e_upd;

  always @(posedge clk) begin
    bit          apply, wrote;
    logic [31:0] status;
    if (rst) begin
      m_stage[0] = 32'h16;  m_stage[1] = 32'h404;
      m_live[0]  = 32'h16;  m_live[1]  = 32'h404;
      m_pend = 0; m_busy = 0; m_errs = 0;
      e_ack = 0; e_err = 0; e_dat = 0; e_upd = 0;
    end else begin
      apply  = m_pend && idle;
      status = {16'h0, 8'(m_errs), 6'h0, idle, m_pend};
      wrote  = 0;
      e_ack = 0; e_err = 0; e_dat = 0;
      e_upd = apply;
      if (apply) begin
        m_live[0] = m_stage[0];
        m_live[1] = m_stage[1];
      end
      if (!m_busy && cyc && stb) begin
        m_busy = 1;
        if (adr >= 4 || (adr == 3 && we)) begin
          e_err = 1;
          if (m_errs < 255) m_errs++;
        end else begin
          e_ack = 1;
          if (!we) begin
            case (adr)
              4'd0: e_dat = m_stage[0];
              4'd1: e_dat = m_stage[1];
              4'd2: e_dat = status;
              default: e_dat = 32'h4852_0001;
            endcase
          end else if (adr < 2) begin
            for (int b = 0; b < 4; b++)
              if (sel[b]) m_stage[adr[0]][8*b +: 8] = wdat[8*b +: 8];
            wrote = (sel != 0);
          end else if (adr == 2 && wdat[31] && sel[3]) begin
            m_errs = 0;
          end
        end
      end else begin
        m_busy = 0;
      end
      if (wrote)      m_pend = 1;
      else if (apply) m_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack",        32'(wb_ack_o),   32'(e_ack));
      chk("err",        32'(wb_err_o),   32'(e_err));
      chk("rdata",      wb_dat_o,        e_dat);
      chk("cfg_update", 32'(cfg_update), 32'(e_upd));
      chk("cfg_ctrl",   cfg_ctrl,        m_live[0]);
      chk("cfg_timing", cfg_timing,      m_live[1]);
    end
  end

  task automatic wb_access(input bit t_we, input logic [3:0] t_adr, input logic [31:0] t_dat,
                           input logic [3:0] t_sel, input bit t_idle,
                           output logic [31:0] rdat, output logic ack, output logic err);
    @(negedge clk);
    cyc = 1; stb = 1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel; idle = t_idle;
    @(posedge clk);
    #1 cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    rdat = wb_dat_o; ack = wb_ack_o; err = wb_err_o;
  endtask

  logic [31:0] rd;
  logic        a, e;
  int          upd_cnt;

  initial begin
    rst = 1;
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_ctrl", cfg_ctrl, 32'h16);
    chk("rst_timing", cfg_timing, 32'h404);
    rst = 0;

    wb_access(0, 4'd0, 0, 4'h0, 0, rd, a, e);
    chk("rd_ctrl", rd, 32'h16);  chk("rd_ctrl_ack", 32'(a), 32'h1);
    wb_access(0, 4'd1, 0, 4'h0, 0, rd, a, e);
    chk("rd_timing", rd, 32'h404);
    wb_access(0, 4'd3, 0, 4'h0, 0, rd, a, e);
    chk("rd_id", rd, 32'h4852_0001);

    // Byte-masked CTRL write held off while the core is busy
    wb_access(1, 4'd0, 32'hA5A5_A5A5, 4'b0011, 0, rd, a, e);
    chk("wr_ctrl_ack", 32'(a), 32'h1);
    wb_access(0, 4'd0, 0, 4'h0, 0, rd, a, e);
    chk("stage_ctrl", rd, 32'h0000_A5A5);
    wb_access(0, 4'd2, 0, 4'h0, 0, rd, a, e);
    chk("status_pend", rd, 32'h1);
    chk("live_held", cfg_ctrl, 32'h16);
    idle = 1;
    @(negedge clk);
    chk("live_applied", cfg_ctrl, 32'h0000_A5A5);
    chk("apply_pulse", 32'(cfg_update), 32'h1);
    wb_access(0, 4'd2, 0, 4'h0, 1, rd, a, e);
    chk("status_idle", rd, 32'h2);

    // Coalesced TIMING writes
    wb_access(1, 4'd1, 32'h11, 4'hF, 0, rd, a, e);
    wb_access(1, 4'd1, 32'h22, 4'hF, 0, rd, a, e);
    idle = 1;
    upd_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (cfg_update) upd_cnt++;
    end
    chk("coalesce_cnt", 32'(upd_cnt), 32'h1);
    chk("coalesce_val", cfg_timing, 32'h22);

    // Write landing on the same edge as an apply
    wb_access(1, 4'd1, 32'h33, 4'hF, 0, rd, a, e);
    wb_access(1, 4'd1, 32'h44, 4'hF, 1, rd, a, e);
    chk("same_edge_live", cfg_timing, 32'h33);
    @(negedge clk);
    chk("second_apply", cfg_timing, 32'h44);
    chk("second_pulse", 32'(cfg_update), 32'h1);

    // Error terminations, counter clear and saturation
    wb_access(0, 4'd7, 0, 4'h0, 1, rd, a, e);
    chk("unmapped_err", 32'(e), 32'h1);  chk("unmapped_ack", 32'(a), 32'h0);
    wb_access(1, 4'd3, 32'hFFFF_FFFF, 4'hF, 1, rd, a, e);
    chk("wr_id_err", 32'(e), 32'h1);
    wb_access(0, 4'd2, 0, 4'h0, 1, rd, a, e);
    chk("err_count2", rd, 32'h0000_0202);
    wb_access(1, 4'd2, 32'h8000_0000, 4'b1000, 1, rd, a, e);
    wb_access(0, 4'd2, 0, 4'h0, 1, rd, a, e);
    chk("err_cleared", rd, 32'h2);
    for (int i = 0; i < 300; i++) wb_access(0, 4'($urandom_range(4, 15)), 0, 4'h0, 1, rd, a, e);
    wb_access(0, 4'd2, 0, 4'h0, 1, rd, a, e);
    chk("err_sat", rd, 32'h0000_FF02);

    // Reset coinciding with a sampled strobe drops the access
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 4'd0; wdat = 32'hDEAD_BEEF; sel = 4'hF; rst = 1;
    @(posedge clk);
    #1 cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("rst_no_ack", 32'({wb_ack_o, wb_err_o}), 32'h0);
    rst = 0;
    wb_access(0, 4'd0, 0, 4'h0, 1, rd, a, e);
    chk("rst_ctrl_rb", rd, 32'h16);
    wb_access(0, 4'd2, 0, 4'h0, 1, rd, a, e);
    chk("rst_status_rb", rd, 32'h2);

    // Random traffic, including requests during the response cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 249) == 0);
      cyc  = ($urandom_range(0, 3) != 0);
      stb  = ($urandom_range(0, 2) != 0);
      we   = $urandom_range(0, 1);
      adr  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      wdat = $urandom;
      sel  = 4'($urandom_range(0, 15));
      idle = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rst = 0; cyc = 0; stb = 0; we = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
